// File: rtl/pea_sched_pkg.sv
// Purpose: shared mode codes and FSM state encoding for the PEA firing scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pea_sched_pkg;

   // Actor mode codes; 11 is never a legal mode.
   localparam logic [1:0] SETUP_INSTR  = 2'b00;
   localparam logic [1:0] INSTR        = 2'b01;
   localparam logic [1:0] OUTPUT       = 2'b10;
   localparam logic [1:0] MODE_ILLEGAL = 2'b11;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CHECK  = 3'd1,
      FIRE   = 3'd2,
      WAIT   = 3'd3,
      SETTLE = 3'd4,
      ERROR  = 3'd5
   } sched_state_t;

   function automatic logic mode_legal(input logic [1:0] mode);
      return mode != MODE_ILLEGAL;
   endfunction

endpackage

// File: rtl/pea_sched_timer.sv
// Purpose: TW-bit cycle counter with clear/increment and a runtime terminal-count compare.
// Latency: count updates one cycle after clr/inc; at_limit is a compare on the registered count.
// Backpressure: none; clr has priority over inc.
//
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   clr, inc      clear (priority) and increment controls
//   limit         terminal count to compare against
//   at_limit      high while the current count equals limit
module pea_sched_timer #(
   parameter int TW = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   input  logic [TW-1:0] limit,
   output logic          at_limit
);

   logic [TW-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + TW'(1);
      end
   end

   assign at_limit = (count == limit);

endmodule

// File: rtl/pea_fire_scheduler.sv
// Purpose: self-timed CFDF firing scheduler driving the PEA actor's invoke pulse and mode select.
// Latency: start->invoke 2 cycles with enable high; FC->next invoke >= 3 cycles (SETTLE, CHECK, FIRE).
// Backpressure: firing waits in CHECK while enable is low; aborts with starved after STALL_LIMIT cycles.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   start/stop        schedule control from the system controller
//   clear_err         leave ERROR, clearing the sticky error flags
//   enable            PEA_enable result for next_mode_out
//   FC, next_mode_in  firing-complete and the actor's next mode (valid with FC)
//   max_firings       firing budget, 0 = unbounded
//   invoke            one-cycle invoke pulse to the actor
//   next_mode_out     registered mode select to the actor and PEA_enable
//   busy/done/starved status; done and starved are one-cycle pulses
//   timeout_err/mode_err  sticky error flags
//   fire_count        completed firings since the last start
module pea_fire_scheduler
   import pea_sched_pkg::*;
#(
   parameter int CW          = 16,
   parameter int TW          = 12,
   parameter int FC_TIMEOUT  = 4000,
   parameter int STALL_LIMIT = 1000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   input  logic          clear_err,
   input  logic          enable,
   input  logic          FC,
   input  logic [1:0]    next_mode_in,
   input  logic [CW-1:0] max_firings,
   output logic          invoke,
   output logic [1:0]    next_mode_out,
   output logic          busy,
   output logic          done,
   output logic          starved,
   output logic          timeout_err,
   output logic          mode_err,
   output logic [CW-1:0] fire_count
);

   localparam logic [TW-1:0] STALL_TC = TW'(STALL_LIMIT - 1);
   localparam logic [TW-1:0] FC_TC    = TW'(FC_TIMEOUT - 1);

   sched_state_t  state, state_d;
   logic          stop_pend, stop_pend_d;
   logic [1:0]    mode_d;
   logic [CW-1:0] count_d;
   logic          invoke_d, busy_d, done_d, starved_d, timeout_d, moderr_d;

   logic          tmr_clr, tmr_inc, tmr_at_limit;
   logic [TW-1:0] tmr_limit;

   // CHECK and WAIT never overlap, so one timer serves both the stall and FC timeouts.
   pea_sched_timer #(.TW(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clr      (tmr_clr),
      .inc      (tmr_inc),
      .limit    (tmr_limit),
      .at_limit (tmr_at_limit)
   );

   always_comb begin
      state_d     = state;
      stop_pend_d = stop_pend;
      mode_d      = next_mode_out;
      count_d     = fire_count;
      timeout_d   = timeout_err;
      moderr_d    = mode_err;
      done_d      = 1'b0;
      starved_d   = 1'b0;
      tmr_clr     = 1'b0;
      tmr_inc     = 1'b0;
      tmr_limit   = FC_TC;

      case (state)
         IDLE: begin
            stop_pend_d = 1'b0;
            // next_mode_out is deliberately kept so a restarted schedule resumes its mode.
            if (start) begin
               state_d = CHECK;
               count_d = '0;
               tmr_clr = 1'b1;
            end
         end
         CHECK: begin
            tmr_limit = STALL_TC;
            if (stop) begin
               state_d = IDLE;
            end else if (enable) begin
               state_d = FIRE;
            end else begin
               tmr_inc = 1'b1;
               if (tmr_at_limit) begin
                  state_d   = IDLE;
                  starved_d = 1'b1;
               end
            end
         end
         FIRE: begin
            tmr_clr = 1'b1;
            if (stop) stop_pend_d = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            // A stop here cannot abandon the firing; it is deferred to SETTLE.
            tmr_inc = 1'b1;
            if (stop) stop_pend_d = 1'b1;
            if (FC) begin
               if (!mode_legal(next_mode_in)) begin
                  state_d  = ERROR;
                  moderr_d = 1'b1;
               end else begin
                  mode_d  = next_mode_in;
                  count_d = fire_count + CW'(1);
                  state_d = SETTLE;
               end
            end else if (tmr_at_limit) begin
               state_d   = ERROR;
               timeout_d = 1'b1;
            end
         end
         SETTLE: begin
            // Gives the actor FIFOs and the enable path a cycle to reflect the new mode.
            if ((max_firings != '0) && (fire_count == max_firings)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (stop_pend) begin
               state_d = IDLE;
            end else begin
               state_d = CHECK;
               tmr_clr = 1'b1;
            end
         end
         ERROR: begin
            if (clear_err) begin
               state_d   = IDLE;
               timeout_d = 1'b0;
               moderr_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      invoke_d = (state_d == FIRE);
      busy_d   = (state_d == CHECK) || (state_d == FIRE) ||
                 (state_d == WAIT)  || (state_d == SETTLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         stop_pend     <= 1'b0;
         invoke        <= 1'b0;
         next_mode_out <= SETUP_INSTR;
         busy          <= 1'b0;
         done          <= 1'b0;
         starved       <= 1'b0;
         timeout_err   <= 1'b0;
         mode_err      <= 1'b0;
         fire_count    <= '0;
      end else begin
         state         <= state_d;
         stop_pend     <= stop_pend_d;
         invoke        <= invoke_d;
         next_mode_out <= mode_d;
         busy          <= busy_d;
         done          <= done_d;
         starved       <= starved_d;
         timeout_err   <= timeout_d;
         mode_err      <= moderr_d;
         fire_count    <= count_d;
      end
   end

endmodule

// File: tb/tb_pea_fire_scheduler.sv
// Purpose: self-checking bench for pea_fire_scheduler against a firing-level reference model.
// Latency: checks start->invoke, FC->invoke, stall and FC-timeout distances.
// Backpressure: enable is held low or randomized to exercise the CHECK wait.
module tb_pea_fire_scheduler;

   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst, start, stop, clear_err, enable, FC;
   logic [1:0]    next_mode_in;
   logic [CW-1:0] max_firings;
   logic          invoke, busy, done, starved, timeout_err, mode_err;
   logic [1:0]    next_mode_out;
   logic [CW-1:0] fire_count;

   always #5 clk = ~clk;

   pea_fire_scheduler #(
      .CW(CW), .TW(12), .FC_TIMEOUT(4000), .STALL_LIMIT(1000)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .clear_err(clear_err),
      .enable(enable), .FC(FC), .next_mode_in(next_mode_in), .max_firings(max_firings),
      .invoke(invoke), .next_mode_out(next_mode_out), .busy(busy), .done(done),
      .starved(starved), .timeout_err(timeout_err), .mode_err(mode_err),
      .fire_count(fire_count)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Output monitor: counts pulses and records the mode presented at each invoke.
   int         inv_cnt = 0, done_cnt = 0, starved_cnt = 0, dbl_cnt = 0;
   logic       inv_prev = 1'b0;
   logic [1:0] inv_modes[$];

   always @(negedge clk) begin
      if (invoke === 1'b1) begin
         inv_cnt++;
         inv_modes.push_back(next_mode_out);
         if (inv_prev) dbl_cnt++;
      end
      inv_prev = (invoke === 1'b1);
      if (done === 1'b1) done_cnt++;
      if (starved === 1'b1) starved_cnt++;
   end

   // Reference model: the actor's current mode and completed firings since start.
   logic [1:0] model_mode;
   int         model_count;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      model_count = 0;
   endtask

   task automatic wait_inv(input int budget, input bit rnd_en, output int waited);
      bit seen;
      seen   = 1'b0;
      waited = 0;
      while (!seen && waited < budget) begin
         @(negedge clk);
         waited++;
         if (invoke === 1'b1) seen = 1'b1;
         else if (rnd_en) enable = ($urandom_range(0, 3) != 0);
      end
      if (!seen) chk("inv_wait", invoke, 1);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b0) chk("idle_wait", busy, 0);
   endtask

   // One FC cycle from the actor; a legal mode completes the firing in the model.
   task automatic fire_fc(input logic [1:0] m);
      FC = 1'b1;
      next_mode_in = m;
      @(negedge clk);
      FC = 1'b0;
      next_mode_in = 2'($urandom_range(0, 3));
      if (m != 2'b11) begin
         model_mode = m;
         model_count++;
      end
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         w, cnt, i0, d0, s0, mb, mf;
      logic [1:0] t1_modes [3];
      logic [1:0] expq[$];
      logic [1:0] newm;

      rst = 1'b0; start = 1'b0; stop = 1'b0; clear_err = 1'b0;
      enable = 1'b0; FC = 1'b0; next_mode_in = 2'b00; max_firings = '0;
      model_mode = 2'b00; model_count = 0;
      t1_modes = '{2'd1, 2'd1, 2'd2};

      // Reset state
      tick(3);
      chk("rst_invoke", invoke, 0);
      chk("rst_mode", next_mode_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_starved", starved, 0);
      chk("rst_timeout", timeout_err, 0);
      chk("rst_moderr", mode_err, 0);
      chk("rst_count", fire_count, 0);
      rst = 1'b1;
      tick(2);

      // 1: three firings, FC 10 cycles after each invoke
      max_firings = 3; enable = 1'b1;
      i0 = inv_cnt; d0 = done_cnt; mb = inv_modes.size();
      expq.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; model_count = 0;
      chk("t1_inv_early", invoke, 0);
      @(negedge clk);
      chk("t1_start2inv", invoke, 1);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin
            wait_inv(50, 1'b0, w);
            chk("t1_fc2inv", w + 1, 3);
         end
         expq.push_back(model_mode);
         tick(10);
         fire_fc(t1_modes[k]);
      end
      wait_idle(20);
      tick(2);
      chk("t1_invokes", inv_cnt - i0, 3);
      chk("t1_done", done_cnt - d0, 1);
      chk("t1_count", fire_count, model_count);
      chk("t1_mode", next_mode_out, model_mode);
      chk("t1_busy", busy, 0);
      for (int k = 0; k < 3; k++)
         chk("t1_inv_mode", inv_modes[mb + k], expq[k]);

      // 2: enable held low -> starved
      enable = 1'b0; max_firings = '0;
      i0 = inv_cnt; s0 = starved_cnt;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; model_count = 0;
      cnt = 1;
      while (starved !== 1'b1 && cnt < 1200) begin
         @(negedge clk);
         cnt++;
      end
      // start-sampling cycle plus 1000 CHECK cycles
      chk("t2_stall_cycles", cnt, 1001);
      tick(3);
      chk("t2_starved", starved_cnt - s0, 1);
      chk("t2_invokes", inv_cnt - i0, 0);
      chk("t2_busy", busy, 0);
      chk("t2_count", fire_count, model_count);
      chk("t2_mode_kept", next_mode_out, model_mode);

      // 3: FC never arrives -> timeout, then error recovery
      enable = 1'b1; max_firings = '0;
      i0 = inv_cnt;
      pulse_start();
      wait_inv(10, 1'b0, w);
      cnt = 0;
      while (timeout_err !== 1'b1 && cnt < 4200) begin
         @(negedge clk);
         cnt++;
      end
      chk("t3_timeout_gap", (cnt == 4000 || cnt == 4001), 1);
      tick(5);
      chk("t3_timeout", timeout_err, 1);
      chk("t3_invokes", inv_cnt - i0, 1);
      chk("t3_busy", busy, 0);
      pulse_start();
      tick(5);
      chk("t3_start_ignored", inv_cnt - i0, 1);
      chk("t3_still_err", timeout_err, 1);
      start = 1'b1; clear_err = 1'b1;
      @(negedge clk);
      start = 1'b0; clear_err = 1'b0;
      tick(3);
      chk("t3_clear_only_busy", busy, 0);
      chk("t3_cleared", timeout_err, 0);
      chk("t3_clear_noinv", inv_cnt - i0, 1);
      max_firings = 1;
      pulse_start();
      wait_inv(10, 1'b0, w);
      chk("t3_restart_inv", invoke, 1);
      tick(3);
      fire_fc(2'b01);
      wait_idle(20);
      chk("t3_count", fire_count, model_count);
      chk("t3_mode", next_mode_out, model_mode);

      // 4: illegal mode on FC
      max_firings = '0;
      pulse_start();
      wait_inv(10, 1'b0, w);
      tick(4);
      fire_fc(2'b11);
      tick(3);
      chk("t4_moderr", mode_err, 1);
      chk("t4_mode_kept", next_mode_out, model_mode);
      chk("t4_count", fire_count, model_count);
      chk("t4_busy", busy, 0);
      i0 = inv_cnt;
      pulse_start();
      tick(3);
      chk("t4_in_error", busy, 0);
      chk("t4_no_inv", inv_cnt - i0, 0);
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      tick(1);
      chk("t4_cleared", mode_err, 0);

      // 5: stop during WAIT lets the firing finish
      max_firings = '0;
      pulse_start();
      i0 = inv_cnt;
      wait_inv(10, 1'b0, w);
      tick(3);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      tick(4);
      newm = (model_mode == 2'd2) ? 2'd0 : model_mode + 2'd1;
      fire_fc(newm);
      chk("t5_settle_busy", busy, 1);
      @(negedge clk);
      chk("t5_idle", busy, 0);
      tick(5);
      chk("t5_count", fire_count, model_count);
      chk("t5_mode", next_mode_out, model_mode);
      chk("t5_invokes", inv_cnt - i0, 1);

      // 6: reset during WAIT, late FC ignored
      pulse_start();
      wait_inv(10, 1'b0, w);
      tick(3);
      i0 = inv_cnt;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_mode = 2'b00; model_count = 0;
      chk("t6_invoke", invoke, 0);
      chk("t6_mode", next_mode_out, model_mode);
      chk("t6_busy", busy, 0);
      chk("t6_count", fire_count, model_count);
      chk("t6_flags", {done, starved, timeout_err, mode_err}, 0);
      tick(2);
      FC = 1'b1; next_mode_in = 2'b10;
      @(negedge clk);
      FC = 1'b0;
      tick(10);
      chk("t6_late_mode", next_mode_out, model_mode);
      chk("t6_late_count", fire_count, model_count);
      chk("t6_late_busy", busy, 0);
      chk("t6_late_inv", inv_cnt - i0, 0);

      // Randomized budgets, modes, FC delays and enable gaps
      for (int r = 0; r < 6; r++) begin
         mf = $urandom_range(1, 5);
         max_firings = CW'(mf);
         i0 = inv_cnt; d0 = done_cnt; mb = inv_modes.size();
         expq.delete();
         pulse_start();
         for (int k = 0; k < mf; k++) begin
            wait_inv(300, 1'b1, w);
            expq.push_back(model_mode);
            tick($urandom_range(1, 20));
            fire_fc(2'($urandom_range(0, 2)));
         end
         enable = 1'b1;
         wait_idle(60);
         tick(2);
         chk("rnd_invokes", inv_cnt - i0, mf);
         chk("rnd_done", done_cnt - d0, 1);
         chk("rnd_count", fire_count, model_count);
         chk("rnd_mode", next_mode_out, model_mode);
         for (int k = 0; k < mf; k++)
            chk("rnd_inv_mode", inv_modes[mb + k], expq[k]);
      end

      chk("no_back_to_back_invoke", dbl_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
